// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between the CPU and the renderer, posting CPU writes during DRAW
module vram_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int WQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lcd_ena,
    input  logic [1:0]                  phase,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic                        cpu_ack,
    output logic [DATA_W-1:0]           cpu_rdata,
    input  logic [ADDR_W-1:0]           ren_addr,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(WQ_DEPTH):0]   wq_count,
    output logic                        wq_full
);
    localparam int PW = $clog2(WQ_DEPTH);
    typedef enum logic [1:0] {S_CPU, S_DRAIN, S_REN} state_t;
    state_t                 own;
    logic                   ren_own, accept, push, pop;
    logic [ADDR_W-1:0]      q_addr [WQ_DEPTH];
    logic [DATA_W-1:0]      q_data [WQ_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    // Ownership is decided combinationally so the renderer takes the port in the very cycle DRAW starts
    assign ren_own = lcd_ena && phase == 2'd3;
    assign own     = ren_own ? S_REN : (wq_count != '0) ? S_DRAIN : S_CPU;
    assign wq_full = wq_count == (PW+1)'(WQ_DEPTH);
    assign accept  = !rst && cpu_req && !cpu_ack && (own == S_CPU || (cpu_we ? !wq_full : own == S_REN));
    assign push    = accept && cpu_we && own != S_CPU;
    assign pop     = !rst && own == S_DRAIN;
    always_comb begin
        mem_addr  = (!rst && own == S_REN) ? ren_addr : pop ? q_addr[rd_ptr] : cpu_addr;
        mem_we    = pop || (accept && cpu_we && own == S_CPU);
        mem_wdata = pop ? q_data[rd_ptr] : cpu_wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '1;
            wq_count  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            cpu_ack <= accept;
            if (accept && !cpu_we)
                cpu_rdata <= (own == S_REN) ? '1 : mem_rdata;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            wq_count <= wq_count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= cpu_addr;
            q_data[wr_ptr] <= cpu_wdata;
        end
    end
endmodule
